alu_req_arbiter: RTL and testbench

//  Shares the single 4-bit ALU between four requesters. Round-robin picks one pending request, drives its index
//  as the 2-bit select (S1,S0) into the 2-to-4 decoder that enables that requester's operand path, issues the
//  op, waits ALU_LAT cycles, then returns the result to the winner with a one-cycle done pulse.

---
 rtl/alu_req_arbiter_pkg.sv | 25 ++
 rtl/alu_req_arbiter_if.sv | 39 +++
 rtl/alu_req_arbiter_rr_pick4.sv | 47 ++++
 rtl/alu_req_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_arb_pkg : state encoding, ALU opcodes and requester count            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/alu_req_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | alu_req_arbiter_if : requester-side and ALU-side signals of the arbiter  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface alu_req_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int DW = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] op_a;
  logic [N_REQ*DW-1:0] op_b;
  logic [N_REQ*2-1:0]  opc;
  logic [1:0]          sel;
  logic [DW-1:0]       alu_a;
  logic [DW-1:0]       alu_b;
  logic [1:0]          alu_op;
  logic                alu_start;
  logic [DW-1:0]       alu_res;
  logic                alu_cout;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [DW:0]         res;

  // slave = the arbiter, master = requesters plus ALU
  modport slave (
    input  req, op_a, op_b, opc, alu_res, alu_cout,
    output sel, alu_a, alu_b, alu_op, alu_start, gnt, done, res
  );

  modport master (
    output req, op_a, op_b, opc, alu_res, alu_cout,
    input  sel, alu_a, alu_b, alu_op, alu_start, gnt, done, res
  );
endinterface

`default_nettype wire

// File: rtl/alu_req_arbiter_rr_pick4.sv
// +--------------------------------------------------------------------------+
// | rr_pick4 : 4-way winner pick; round-robin after last, or fixed priority  |
// | when ARB_FIXED_PRIO_EN is defined.  Revision 1.0                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] win,
  output logic       valid
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
  end
`else
  logic       found;
  logic [1:0] idx;

  // Search last+1, last+2, ... with natural 2-bit wrap; last itself is tried last.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`endif

  assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/alu_req_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_req_arbiter : shares one ALU between four requesters (ISSUE/WAIT/    |
// | RESP FSM); ARB_FIXED_PRIO_EN selects fixed priority.  Revision 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW      = 4,
  parameter int ALU_LAT = 1
)
(
  input  logic             clk,
  input  logic             rst_n,
  alu_req_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             start_q, start_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [DW:0]      res_q, res_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [1:0]       win;
  logic             win_vld;

  rr_pick4 u_pick (
    .req   (bus.req),
    .last  (last_q),
    .win   (win),
    .valid (win_vld)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    start_d = 1'b0;
    gnt_d   = gnt_q;
    done_d  = '0;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = ISSUE;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          a_d     = bus.op_a[win*DW +: DW];
          b_d     = bus.op_b[win*DW +: DW];
          op_d    = bus.opc[win*2 +: 2];
        end
      end
      ISSUE: begin
        // start is seen in the first WAIT cycle, which is where latency counting begins
        start_d = 1'b1;
        cnt_d   = 4'(ALU_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          res_d   = {bus.alu_cout, bus.alu_res};
          done_d  = gnt_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_d  = sel_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'd0;
      start_q <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      start_q <= start_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_start = start_q;
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.res       = res_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_alu_req_arbiter : directed stimulus with a done/res scoreboard        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  typedef struct packed {
    logic [3:0] done;
    logic [4:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc;

  always #5 clk = ~clk;

  alu_req_arbiter_if #(.DW(4)) b1 ();
  alu_req_arbiter_if #(.DW(4)) b3 ();

  alu_req_arbiter #(.DW(4), .ALU_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  alu_req_arbiter #(.DW(4), .ALU_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  function automatic logic [4:0] alu5(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      OP_ADD:  alu5 = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu5 = {1'b0, a} - {1'b0, b};
      OP_AND:  alu5 = {1'b0, a & b};
      default: alu5 = {1'b0, a | b};
    endcase
  endfunction

  assign {b1.alu_cout, b1.alu_res} = alu5(b1.alu_a, b1.alu_b, b1.alu_op);
  assign {b3.alu_cout, b3.alu_res} = alu5(b3.alu_a, b3.alu_b, b3.alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] outs1();
    outs1 = {b1.sel, b1.alu_a, b1.alu_b, b1.alu_op, b1.alu_start, b1.gnt, b1.done, b1.res};
  endfunction

  function automatic logic [25:0] outs3();
    outs3 = {b3.sel, b3.alu_a, b3.alu_b, b3.alu_op, b3.alu_start, b3.gnt, b3.done, b3.res};
  endfunction

  task automatic push(input logic [3:0] d, input logic [4:0] r);
    exp_t e;
    e.done = d;
    e.res  = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b1.done == 4'b0 && n < 30);
    if (b1.done == 4'b0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=no_done required=done_within_30", name);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && b1.done != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {28'b0, b1.done}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done", {28'b0, b1.done}, {28'b0, mon_e.done});
        chk("res", {27'b0, b1.res}, {27'b0, mon_e.res});
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    b1.req  = 4'b0;
    b1.op_a = {4'hF, 4'h9, 4'h5, 4'h3};
    b1.op_b = {4'h2, 4'h8, 4'h6, 4'h4};
    b1.opc  = {OP_OR, OP_AND, OP_SUB, OP_ADD};
    b3.req  = 4'b0;
    b3.op_a = {12'h0, 4'hF};
    b3.op_b = {12'h0, 4'h1};
    b3.opc  = {6'b0, OP_ADD};

    // Test 1: reset state and quiet idle
    repeat (2) @(negedge clk);
    chk("rst_outs1", {6'b0, outs1()}, 32'h0);
    chk("rst_outs3", {6'b0, outs3()}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs1", {6'b0, outs1()}, 32'h0);
    end

    // Test 3: all four held -> 0,1,2,3,0 (fixed priority: always 0)
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) push(4'b0001, 5'h07);
`else
    push(4'b0001, 5'h07);
    push(4'b0010, 5'h1F);
    push(4'b0100, 5'h08);
    push(4'b1000, 5'h0F);
    push(4'b0001, 5'h07);
`endif
    @(negedge clk);
    b1.req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_done("t3_done", cyc);
    b1.req = 4'b0;

    // Test 2: single request, cycle-exact timing
    @(negedge clk);
    b1.req = 4'b0001;
    push(4'b0001, 5'h07);
    @(negedge clk);
    chk("t2_gnt", {28'b0, b1.gnt}, 32'h1);
    chk("t2_sel", {30'b0, b1.sel}, 32'h0);
    chk("t2_start_early", {31'b0, b1.alu_start}, 32'h0);
    @(negedge clk);
    chk("t2_start", {31'b0, b1.alu_start}, 32'h1);
    chk("t2_alu_a", {28'b0, b1.alu_a}, 32'h3);
    chk("t2_alu_b", {28'b0, b1.alu_b}, 32'h4);
    chk("t2_alu_op", {30'b0, b1.alu_op}, {30'b0, OP_ADD});
    wait_done("t2_done", cyc);
    chk("t2_done_lat", cyc, 32'd1);
    b1.req = 4'b0;
    @(negedge clk);
    chk("t2_gnt_clear", {28'b0, b1.gnt}, 32'h0);

    // Test 4: new request during WAIT is arbitrated only after RESP
    b1.req = 4'b0100;
    push(4'b0100, 5'h08);
    push(4'b0010, 5'h1F);
    @(negedge clk);
    @(negedge clk);
    b1.req = 4'b0110;
    wait_done("t4_done_a", cyc);
    b1.req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("t4_gnt2", {28'b0, b1.gnt}, 32'h2);
    chk("t4_sel2", {30'b0, b1.sel}, 32'h1);
    wait_done("t4_done_b", cyc);
    b1.req = 4'b0;

    // Test 5: ALU_LAT=3 instance, carry out
    @(negedge clk);
    b3.req = 4'b0001;
    cyc = 0;
    while (!b3.alu_start && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_start_seen", {31'b0, b3.alu_start}, 32'h1);
    cyc = 0;
    while (b3.done == 4'b0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_lat", cyc, 32'd3);
    chk("t5_done", {28'b0, b3.done}, 32'h1);
    chk("t5_res", {27'b0, b3.res}, 32'h10);
    b3.req = 4'b0;

    // Test 6: async reset during WAIT, then arbitration restarts from last=3
    @(negedge clk);
    b1.req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_wait", {31'b0, b1.alu_start}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_clear", {6'b0, outs1()}, 32'h0);
    b1.req = 4'b0;
    @(negedge clk);
    chk("t6_held_clear", {6'b0, outs1()}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    b1.req = 4'b1111;
    push(4'b0001, 5'h07);
    wait_done("t6_done", cyc);
    b1.req = 4'b0;

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
